fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 imem_req  output  1  instruction-memory read request.
REQ-005 imem_addr  output  32  read address, word-aligned.
REQ-006 imem_ready  input  1  memory completes the request this cycle; imem_rdata is valid in the same cycle.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 instr  output  32  head instruction presented to the controller/decoder.
REQ-009 instr_valid  output  1  instr holds a real fetched instruction.
REQ-010 instr_accept  input  1  consumer takes the head entry this cycle.
REQ-011 pc_out  output  32  address of the head instruction.
REQ-012 pc_plus8  output  32  pc_out + 8 (ARM R15 read value), modulo 2^32.
REQ-013 branch_taken  input  1  redirect request (driven from PCSrc).
REQ-014 branch_target  input  32  redirect address.

Function
REQ-015 The block SHALL hold a 2-entry FIFO of {pc, instr} pairs plus a 32-bit fetch_pc register.
REQ-016 imem_req SHALL be 1 exactly when reset=0, branch_taken=0, and FIFO count < 2.
REQ-017 imem_addr SHALL equal fetch_pc and SHALL stay stable while imem_req=1 and imem_ready=0.
REQ-018 A response SHALL be accepted in any cycle with imem_req=1 and imem_ready=1.
  - {fetch_pc, imem_rdata} is pushed.
  - fetch_pc <= fetch_pc + 4; 0xFFFFFFFC wraps to 0x00000000.
REQ-019 instr_valid SHALL equal (count > 0); pc_out SHALL equal the head pc.
REQ-020 instr SHALL equal the head word when valid, else the NOP 32'hE1A00000; pc_out SHALL be 0 when invalid.
REQ-021 instr_accept with instr_valid=1 SHALL pop the head; instr_accept with instr_valid=0 SHALL be ignored.
REQ-022 When a push and a pop occur in the same cycle, count SHALL be unchanged and the entries SHALL advance in order.
REQ-023 When branch_taken=1, the block SHALL do all of the following in that cycle:
  - flush the FIFO (count <= 0);
  - set fetch_pc <= {branch_target[31:2], 2'b00};
  - ignore imem_ready/imem_rdata;
  - discard any pending request.
REQ-024 Branch SHALL take priority over a simultaneous accept or response.
REQ-025 Latency SHALL be: for a zero-wait memory, an instruction is visible on instr the cycle after its imem_ready; the first fetch is at the first cycle after reset deasserts.
REQ-026 The state machine SHALL have these states:
  - IDLE: reset held; goes to FETCH when reset deasserts.
  - FETCH: count < 2.
  - FULL: count = 2; returns to FETCH on pop.
  - Any state goes to FETCH on branch; REDIRECT is not a separate state.

Reset
REQ-027 Reset SHALL set fetch_pc=0x00000000, count=0, instr_valid=0, instr=32'hE1A00000, pc_out=0, imem_req=0.
REQ-028 Reset asserted mid-request SHALL abandon the request; imem_ready during reset SHALL be ignored.
REQ-029 Reset SHALL take priority over branch_taken.

Configuration
REQ-030 The macro FETCH_PERF_EN SHALL, when defined, add two 32-bit outputs, both zeroed by reset and saturating at 0xFFFFFFFF:
  - perf_fetched: count of valid pops.
  - perf_flushes: count of branch_taken cycles.
REQ-031 When FETCH_PERF_EN is undefined, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-032 Straight-line fetch: reset, then zero-wait memory with instr_accept=1 -> imem_addr 0,4,8,... and pc_out 0,4,8 on consecutive cycles; pc_plus8 = pc_out + 8.
REQ-033 Backpressure: instr_accept=0 for 5 cycles -> count reaches 2, imem_req=0, head stays pc=0; on release, order is preserved.
REQ-034 Wait states: imem_ready low for 3 cycles -> imem_addr stable at 0x4; instr_valid=0 with instr=E1A00000 while empty.
REQ-035 Branch during an outstanding request with branch_target=0x103 and imem_ready=1 in the same cycle -> response dropped, FIFO empty, next imem_addr=0x100.
REQ-036 Wrap and reset:
  - A branch to 0xFFFFFFFC is followed by fetch address 0x0.
  - Reset asserted with count=2 gives count=0 and imem_req=0 next cycle.
  - With FETCH_PERF_EN defined, perf counters read 0 after that reset.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: 2-entry {pc, instr} prefetch FIFO with branch redirect; FETCH_PERF_EN adds perf_fetched/perf_flushes counters
module fetch_unit (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_accept,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus8,
  input  logic        branch_taken,
  input  logic [31:0] branch_target
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushes
`endif
);
  localparam logic [31:0] NOP = 32'hE1A00000;
  typedef enum logic [1:0] {IDLE, FETCH, FULL} state_t;
  state_t state_q, state_d;
  logic [1:0] count_q, count_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pc0_q, pc0_d, pc1_q, pc1_d, ins0_q, ins0_d, ins1_q, ins1_d;
  logic push, pop, slot1;
  assign imem_req    = !reset && !branch_taken && state_q != FULL;
  assign imem_addr   = fetch_pc_q;
  assign instr_valid = count_q != 2'd0;
  assign instr       = instr_valid ? ins0_q : NOP;
  assign pc_out      = instr_valid ? pc0_q : 32'd0;
  assign pc_plus8    = pc_out + 32'd8;
  assign push        = imem_req && imem_ready;
  assign pop         = instr_accept && instr_valid;
  assign slot1       = count_q == 2'd1 && !pop;
  always_comb begin
    pc0_d      = (push && !slot1) ? fetch_pc_q : pop ? pc1_q : pc0_q;
    ins0_d     = (push && !slot1) ? imem_rdata : pop ? ins1_q : ins0_q;
    pc1_d      = (push && slot1) ? fetch_pc_q : pc1_q;
    ins1_d     = (push && slot1) ? imem_rdata : ins1_q;
    count_d    = branch_taken ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
    fetch_pc_d = branch_taken ? (branch_target & ~32'd3) : push ? fetch_pc_q + 32'd4 : fetch_pc_q;
    state_d    = count_d == 2'd2 ? FULL : FETCH;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= 2'd0;
      fetch_pc_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
    end
    pc0_q  <= pc0_d;
    pc1_q  <= pc1_d;
    ins0_q <= ins0_d;
    ins1_q <= ins1_d;
  end
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d, perf_flushes_q, perf_flushes_d;
  assign perf_fetched = perf_fetched_q;
  assign perf_flushes = perf_flushes_q;
  always_comb begin
    perf_fetched_d = perf_fetched_q + {31'd0, pop && !branch_taken && perf_fetched_q != 32'hFFFFFFFF};
    perf_flushes_d = perf_flushes_q + {31'd0, branch_taken && perf_flushes_q != 32'hFFFFFFFF};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= 32'd0;
      perf_flushes_q <= 32'd0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushes_q <= perf_flushes_d;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random stimulus checked every cycle against a queue-based fetch model
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'hE1A00000;
  logic clk = 1'b0;
  logic reset, imem_ready, instr_accept, branch_taken;
  logic [31:0] imem_rdata, branch_target;
  logic imem_req, instr_valid;
  logic [31:0] imem_addr, instr, pc_out, pc_plus8;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_flushes;
`endif
  int passed = 0;
  int total = 0;
  logic [63:0] q[$];
  logic [31:0] mpc = 32'd0;
  logic [31:0] mfetched = 32'd0;
  logic [31:0] mflushes = 32'd0;
  always #5 clk = ~clk;
  fetch_unit dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .instr_accept(instr_accept), .pc_out(pc_out),
    .pc_plus8(pc_plus8), .branch_taken(branch_taken), .branch_target(branch_target)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_flushes(perf_flushes)
`endif
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  task automatic step(input logic r, input logic br, input logic [31:0] tgt,
                      input logic rdy, input logic [31:0] rd, input logic acc);
    logic req;
    reset = r; branch_taken = br; branch_target = tgt;
    imem_ready = rdy; imem_rdata = rd; instr_accept = acc;
    #1;
    req = !r && !br && q.size() < 2;
    chk("imem_req", {31'd0, imem_req}, {31'd0, req});
    chk("imem_addr", imem_addr, mpc);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, q.size() > 0});
    chk("instr", instr, q.size() > 0 ? q[0][31:0] : NOP);
    chk("pc_out", pc_out, q.size() > 0 ? q[0][63:32] : 32'd0);
    chk("pc_plus8", pc_plus8, (q.size() > 0 ? q[0][63:32] : 32'd0) + 32'd8);
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, mfetched);
    chk("perf_flushes", perf_flushes, mflushes);
`endif
    if (r) begin
      q.delete(); mpc = 0; mfetched = 0; mflushes = 0;
    end else if (br) begin
      q.delete(); mpc = tgt & ~32'd3;
      if (mflushes != 32'hFFFFFFFF) mflushes++;
    end else begin
      if (acc && q.size() > 0) begin
        void'(q.pop_front());
        if (mfetched != 32'hFFFFFFFF) mfetched++;
      end
      if (req && rdy) begin
        q.push_back({mpc, rd});
        mpc = mpc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1; branch_taken = 0; branch_target = 0; imem_ready = 0; imem_rdata = 0; instr_accept = 0;
    @(posedge clk);
    #1;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 32'h1234, 0);
    chk("rst_instr", instr, NOP);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 32'hE0000000 + 32'(i * 4), 1);
    chk("line_pc_out", pc_out, 32'd20);
    chk("line_pc_plus8", pc_plus8, 32'd28);
    chk("line_addr", imem_addr, 32'd24);
    chk("line_instr", instr, 32'hE0000014);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 32'hB0000000 + 32'(i), 0);
    chk("bp_pc_out", pc_out, 32'd0);
    chk("bp_instr", instr, 32'hB0000000);
    chk("bp_addr", imem_addr, 32'd8);
    chk("bp_req", {31'd0, imem_req}, 32'd0);
    step(0, 0, 0, 0, 0, 1);
    chk("bp_release_pc", pc_out, 32'd4);
    chk("bp_release_instr", instr, 32'hB0000001);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'hC0000000, 0);
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 32'hDEAD0000, 1);
    chk("ws_addr", imem_addr, 32'd4);
    chk("ws_valid", {31'd0, instr_valid}, 32'd0);
    chk("ws_instr", instr, NOP);
    step(0, 1, 32'h103, 1, 32'hBAD0BAD0, 1);
    chk("br_valid", {31'd0, instr_valid}, 32'd0);
    chk("br_addr", imem_addr, 32'h100);
    step(0, 0, 0, 1, 32'hA1000100, 0);
    chk("br_pc_out", pc_out, 32'h100);
    step(0, 1, 32'hFFFFFFFC, 0, 0, 0);
    step(0, 0, 0, 1, 32'hA2000000, 0);
    chk("wrap_addr", imem_addr, 32'd0);
    chk("wrap_pc_out", pc_out, 32'hFFFFFFFC);
    chk("wrap_pc_plus8", pc_plus8, 32'd4);
    step(0, 0, 0, 1, 32'hA3000000, 0);
    chk("full_valid", {31'd0, instr_valid}, 32'd1);
    step(1, 0, 0, 1, 32'hA4000000, 0);
    chk("rst2_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst2_addr", imem_addr, 32'd0);
`ifdef FETCH_PERF_EN
    chk("rst2_perf_fetched", perf_fetched, 32'd0);
    chk("rst2_perf_flushes", perf_flushes, 32'd0);
`endif
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 8, $urandom,
           $urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 60);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
